// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared state and trigger-source encodings for the stim trigger scheduler
package stim_pkg;

  // Scheduler states; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STIM    = 2'b01,
    ST_REFRACT = 2'b10
  } stim_state_e;

  // Source of the current or most recently accepted trigger.
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_DISC = 2'b01,
    SRC_SW   = 2'b10
  } stim_src_e;

endpackage

// File: rtl/stim_trigger_scheduler_tick_counter.sv
// rtl/stim_trigger_scheduler_tick_counter.sv - sample-tick counter with clear and terminal-count flag
module stim_trigger_scheduler_tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             dataclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  // Equality against the target on the tick that would reach it; the count never wraps.
  assign count_inc = count + CNT_W'(1);
  assign done      = tick & (count_inc == target);

  // Count ticks since the last clear.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/stim_trigger_scheduler.sv
// rtl/stim_trigger_scheduler.sv - stimulation trigger arbiter with pulse and refractory timing
module stim_trigger_scheduler
  import stim_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              dataclk,
  input  logic              reset,
  input  logic              sample_clk,
  input  logic              enable,
  input  logic [1:0]        trig_en,
  input  logic              disc_stim,
  input  logic              sw_trig,
  input  logic [CNT_W-1:0]  pulse_width,
  input  logic [CNT_W-1:0]  refractory,
  output logic              stim_out,
  output logic [1:0]        stim_src,
  output logic              busy,
  output logic              disc_fsm_mode,
  output logic [DROP_W-1:0] drop_count
);

  logic             sample_clk_q;
  logic             sample_tick;
  logic             sw_pending;
  logic             disc_req;
  logic             sw_req;
  logic             any_req;
  stim_state_e      state_q;
  stim_state_e      state_d;
  stim_src_e        src_q;
  stim_src_e        src_d;
  logic [CNT_W-1:0] pw_q;
  logic [CNT_W-1:0] rf_q;
  logic [CNT_W-1:0] cnt_target;
  logic             cnt_clr;
  logic             cnt_done;
  logic             accept;
  logic             drop_inc;
  logic [DROP_W-1:0] drop_q;

  assign sample_tick = sample_clk & ~sample_clk_q;
  assign disc_req    = sample_tick & disc_stim & trig_en[0];
  assign sw_req      = sample_tick & sw_pending & trig_en[1];
  assign any_req     = disc_req | sw_req;

  // One counter serves both timed states; it is cleared on every state entry.
  assign cnt_target = (state_q == ST_REFRACT) ? rf_q : pw_q;

  stim_trigger_scheduler_tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
    .dataclk (dataclk),
    .reset   (reset),
    .clear   (cnt_clr),
    .tick    (sample_tick),
    .target  (cnt_target),
    .done    (cnt_done)
  );

  assign stim_out      = (state_q == ST_STIM);
  assign busy          = (state_q == ST_STIM) | (state_q == ST_REFRACT);
  assign stim_src      = src_q;
  assign disc_fsm_mode = enable & trig_en[0] & (state_q == ST_IDLE);
  assign drop_count    = drop_q;

  // Next-state, acceptance and drop decisions.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    accept   = 1'b0;
    cnt_clr  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (any_req) begin
          if (enable) begin
            accept  = 1'b1;
            state_d = ST_STIM;
            src_d   = sw_req ? SRC_SW : SRC_DISC;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_STIM: begin
        drop_inc = any_req;
        if (cnt_done) begin
          cnt_clr = 1'b1;
          state_d = (rf_q == '0) ? ST_IDLE : ST_REFRACT;
        end
      end
      ST_REFRACT: begin
        drop_inc = any_req;
        if (cnt_done) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_clr  = 1'b1;
        drop_inc = any_req;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, source, shadow timing and edge-detect registers.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_NONE;
      sample_clk_q <= 1'b0;
      sw_pending   <= 1'b0;
      pw_q         <= '0;
      rf_q         <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      sample_clk_q <= sample_clk;
      sw_pending   <= sw_trig | (sw_pending & ~sample_tick);
      if (accept) begin
        pw_q <= (pulse_width == '0) ? CNT_W'(1) : pulse_width;
        rf_q <= refractory;
      end
    end
  end

  // Saturating count of rejected requests.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_stim_trigger_scheduler.sv
// tb/tb_stim_trigger_scheduler.sv - directed self-checking bench for stim_trigger_scheduler
module tb_stim_trigger_scheduler;

  logic        dataclk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_clk = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  trig_en = 2'b00;
  logic        disc_stim = 1'b0;
  logic        sw_trig = 1'b0;
  logic [15:0] pulse_width = 16'd0;
  logic [15:0] refractory = 16'd0;
  logic        stim_out;
  logic [1:0]  stim_src;
  logic        busy;
  logic        disc_fsm_mode;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;
  logic tick_pending = 1'b0;
  logic q_m;
  int s_cnt;
  int b_cnt;

  stim_trigger_scheduler #(.CNT_W(16), .DROP_W(8)) dut (
    .dataclk       (dataclk),
    .reset         (reset),
    .sample_clk    (sample_clk),
    .enable        (enable),
    .trig_en       (trig_en),
    .disc_stim     (disc_stim),
    .sw_trig       (sw_trig),
    .pulse_width   (pulse_width),
    .refractory    (refractory),
    .stim_out      (stim_out),
    .stim_src      (stim_src),
    .busy          (busy),
    .disc_fsm_mode (disc_fsm_mode),
    .drop_count    (drop_count)
  );

  always #5 dataclk = ~dataclk;

  // Sample clock: high 2 cycles, low 2 cycles; tick_pending flags that the next rising dataclk edge is a sample tick.
  always @(negedge dataclk) begin
    q_m = reset ? sample_clk : 1'b0;
    phase = phase + 1;
    sample_clk = phase[1];
    tick_pending = sample_clk & ~q_m;
  end

  task automatic step();
    @(negedge dataclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_tick();
    for (int i = 0; i < 16 && !tick_pending; i++) step();
    if (!tick_pending) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(output int s, output int b);
    s = 0;
    b = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy !== 1'b1 && stim_out !== 1'b1) break;
      if (busy === 1'b1) b++;
      if (stim_out === 1'b1) s++;
      step();
    end
  endtask

  initial begin
    repeat (4) step();
    check("rst_stim_out", {31'd0, stim_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_src", {30'd0, stim_src}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_dfm_disabled", {31'd0, disc_fsm_mode}, 32'd0);
    enable = 1'b1;
    trig_en = 2'b01;
    pulse_width = 16'd3;
    refractory = 16'd5;
    step();
    check("dfm_enabled_idle", {31'd0, disc_fsm_mode}, 32'd1);
    reset = 1'b1;
    repeat (3) step();

    // Disc trigger: 3-tick pulse, 8-tick busy window.
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    check("t1_stim_rise", {31'd0, stim_out}, 32'd1);
    check("t1_src_disc", {30'd0, stim_src}, 32'd1);
    check("t1_dfm_busy", {31'd0, disc_fsm_mode}, 32'd0);
    measure(s_cnt, b_cnt);
    check("t1_stim_cycles", s_cnt, 32'd12);
    check("t1_busy_cycles", b_cnt, 32'd32);

    // Software and disc together: software wins, no drop.
    trig_en = 2'b11;
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    check("t2_src_sw", {30'd0, stim_src}, 32'd2);
    check("t2_stim_rise", {31'd0, stim_out}, 32'd1);
    measure(s_cnt, b_cnt);
    check("t2_stim_cycles", s_cnt, 32'd12);
    check("t2_drop_zero", {24'd0, drop_count}, 32'd0);

    // Disc request during refractory is dropped.
    trig_en = 2'b01;
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_tick();
      step();
    end
    check("t3_refract_busy", {31'd0, busy}, 32'd1);
    check("t3_refract_stim", {31'd0, stim_out}, 32'd0);
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    check("t3_drop_one", {24'd0, drop_count}, 32'd1);
    check("t3_src_kept", {30'd0, stim_src}, 32'd1);
    for (int i = 0; i < 100 && busy === 1'b1; i++) step();
    check("t3_idle_again", {31'd0, busy}, 32'd0);

    // Disabled requests drop and saturate at 255.
    enable = 1'b0;
    disc_stim = 1'b1;
    step();
    check("t3_dfm_disabled", {31'd0, disc_fsm_mode}, 32'd0);
    for (int k = 0; k < 260; k++) begin
      to_tick();
      step();
    end
    check("t3_drop_sat", {24'd0, drop_count}, 32'd255);
    check("t3_no_stim_disabled", {31'd0, busy}, 32'd0);
    to_tick();
    step();
    to_tick();
    step();
    check("t3_drop_sat_hold", {24'd0, drop_count}, 32'd255);
    disc_stim = 1'b0;
    enable = 1'b1;

    // Zero width and refractory: 1-tick pulse, re-trigger on the tick after returning idle.
    pulse_width = 16'd0;
    refractory = 16'd0;
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    check("t4_stim_rise", {31'd0, stim_out}, 32'd1);
    to_tick();
    step();
    check("t4_stim_fall", {31'd0, stim_out}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    check("t4_reaccept", {31'd0, stim_out}, 32'd1);
    measure(s_cnt, b_cnt);
    check("t4_stim_cycles", s_cnt, 32'd4);
    check("t4_busy_cycles", b_cnt, 32'd4);

    // Reset mid-pulse with a software trigger pending.
    pulse_width = 16'd3;
    refractory = 16'd5;
    trig_en = 2'b11;
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    to_tick();
    step();
    check("t5_mid_stim", {31'd0, stim_out}, 32'd1);
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    reset = 1'b0;
    step();
    check("t5_rst_stim", {31'd0, stim_out}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_src", {30'd0, stim_src}, 32'd0);
    check("t5_rst_drop", {24'd0, drop_count}, 32'd0);
    check("t5_rst_dfm", {31'd0, disc_fsm_mode}, 32'd1);
    reset = 1'b1;
    to_tick();
    step();
    to_tick();
    step();
    check("t5_no_pending", {31'd0, busy}, 32'd0);

    // Width change mid-pulse does not alter the running pulse.
    trig_en = 2'b01;
    to_tick();
    disc_stim = 1'b1;
    step();
    disc_stim = 1'b0;
    pulse_width = 16'd7;
    refractory = 16'd1;
    measure(s_cnt, b_cnt);
    check("t5_shadow_stim", s_cnt, 32'd12);
    check("t5_shadow_busy", b_cnt, 32'd32);
    check("t5_drop_after", {24'd0, drop_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stim_trigger_scheduler.md
STIM_TRIGGER_SCHEDULER -- requirements
Module: stim_trigger_scheduler

Interface
REQ-001 Parameter CNT_W, default 16: width of pulse-width and refractory counters (in sample ticks).
REQ-002 Parameter DROP_W, default 8: width of the saturating dropped-request counter.
REQ-003 dataclk  in  1  sole clock, all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 sample_clk  in  1  sample clock from main sequencer (sample_CLK_out), dataclk-synchronous level.
REQ-006 enable  in  1  master arm; 0 forces IDLE behaviour and blocks acceptance.
REQ-007 trig_en  in  2  bit0 enables discriminator source, bit1 enables software source.
REQ-008 disc_stim  in  1  discriminator stim indication (high while discriminator in stim state).
REQ-009 sw_trig  in  1  one-dataclk software trigger pulse.
REQ-010 pulse_width  in  CNT_W  stim duration in sample ticks.
REQ-011 refractory  in  CNT_W  post-stim lockout in sample ticks.
REQ-012 stim_out  out  1  stimulation pulse.
REQ-013 stim_src  out  2  source of current/last accepted trigger: 01 disc, 10 software, 00 none since reset.
REQ-014 busy  out  1  high in STIM or REFRACT.
REQ-015 disc_fsm_mode  out  1  enable for the discriminator FSM (DAC_fsm_mode): enable & trig_en[0] & state==IDLE.
REQ-016 drop_count  out  DROP_W  saturating count of rejected requests.

Function
REQ-017 sample_tick = sample_clk & ~sample_clk_q (registered copy); all timing counts advance only on sample_tick.
REQ-018 States IDLE, STIM, REFRACT; encoding 2 bits, any illegal code returns to IDLE next cycle with stim_out=0.
REQ-019 sw_trig sets sw_pending register; sw_pending consumed (cleared) at next sample_tick regardless of acceptance.
REQ-020 Disc request = disc_stim & trig_en[0] sampled on sample_tick; sw request = sw_pending & trig_en[1] on sample_tick.
REQ-021 IDLE: on sample_tick with enable=1 and any request -> STIM; software wins if both present, stim_src updated accordingly.
REQ-022 On acceptance pulse_width and refractory latched into shadow registers; later input changes ignored until next acceptance.
REQ-023 pulse_width=0 treated as 1; stim_out registered, rises one dataclk after the accepting tick, lasts exactly max(pulse_width,1) sample ticks.
REQ-024 STIM -> REFRACT on the tick ending the pulse; refractory=0 goes directly STIM -> IDLE on that tick.
REQ-025 REFRACT -> IDLE after refractory sample ticks; new trigger accepted earliest on the following tick.
REQ-026 Any request present at sample_tick while not IDLE, or while enable=0, increments drop_count (by 1 even if both sources), saturating at all-ones.
REQ-027 enable falling in STIM/REFRACT: finish current pulse and refractory normally (no truncation).
REQ-028 Counters never wrap: terminal compare is equality with latched value, counter reset to 0 on each state entry.

Reset
REQ-029 reset=0 at a dataclk edge: state IDLE, stim_out 0, busy 0, stim_src 00, drop_count 0, sw_pending 0, sample_clk_q 0, counters/shadows 0.
REQ-030 Reset mid-STIM drops stim_out on that same edge; no pending trigger survives reset.

Structure
REQ-031 State encoding and stim_src codes SHALL live in shared package stim_pkg, reused by main integration.
REQ-032 One sub-module natural: tick_counter (load/clear, advance on tick, terminal-count flag), instanced for STIM and REFRACT or shared.

Verification
REQ-033 pulse_width=3, refractory=5, disc_stim high at one tick -> stim_out high 3 ticks, busy 8 ticks, stim_src=01.
REQ-034 sw_trig and disc_stim at same tick -> one pulse, stim_src=10, drop_count unchanged.
REQ-035 Second disc request during REFRACT -> ignored, drop_count=1; drop_count forced to 255 stays 255 on further drops.
REQ-036 pulse_width=0, refractory=0 -> 1-tick pulse, back to IDLE, next-tick request accepted.
REQ-037 reset=0 asserted mid-STIM -> stim_out 0 next edge, all outputs at reset values; pulse_width changed mid-STIM without reset -> current pulse length unchanged.
